clip_mem_sequencer: RTL and testbench

Sequences the two-clip sample memory for record and playback.
- Record: accepts samples from the deserializer and writes them to consecutive addresses in the selected clip block.
- Play: reads back at a fixed sample rate and loads each sample into the serializer.
- Tracks the recorded length of each clip and ends each operation by sample count, not by a free-running 2-second timer. Sits between the top-level mode FSM and the memory/serializer/deserializer datapath.

---
 rtl/clip_mem_sequencer.sv | 154 +++++++++++++++
 tb/tb_clip_mem_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_mem_sequencer.sv
// Record/playback sequencer for a two-clip sample memory.
// Record writes deserializer samples to a clip block; play reads them out at a fixed rate.
module clip_mem_sequencer #(
    parameter int unsigned CLIP_LEN = 16000,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned CNT_W    = 14,
    parameter int unsigned RATE_DIV = 6250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              clip_sel,
    input  logic              abort,
    input  logic              des_valid,
    input  logic              ser_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic              ser_load,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  len0,
    output logic [CNT_W-1:0]  len1
);

    localparam int unsigned DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRec,
        StPlayRd,
        StPlayWait,
        StPlayLoad,
        StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len0_q, len0_d;
    logic [CNT_W-1:0]   len1_q, len1_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               mode_q, mode_d;
    logic               clip_q, clip_d;
    logic               err_q, err_d;

    logic               in_play;
    logic               tick;
    logic [CNT_W-1:0]   sel_len;
    logic [CNT_W-1:0]   cur_len;
    logic [CNT_W-1:0]   cnt_inc;

    assign in_play = (state_q == StPlayRd) || (state_q == StPlayWait) || (state_q == StPlayLoad);
    assign tick    = in_play && (div_q == DIV_W'(RATE_DIV - 1));
    assign sel_len = clip_sel ? len1_q : len0_q;
    assign cur_len = clip_q ? len1_q : len0_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len0_d  = len0_q;
        len1_d  = len1_q;
        mode_d  = mode_q;
        clip_d  = clip_q;
        err_d   = 1'b0;
        // Divider free-runs through all play states so a stalled load eats into the next period.
        div_d   = in_play ? (tick ? '0 : div_q + DIV_W'(1)) : '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
                    clip_d = clip_sel;
                    cnt_d  = '0;
                    if (mode) begin
                        state_d = StRec;
                        if (clip_sel) len1_d = '0;
                        else          len0_d = '0;
                    end else if (sel_len != '0) begin
                        state_d = StPlayRd;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRec: begin
                if (des_valid) begin
                    cnt_d = cnt_inc;
                    if (abort || (cnt_q == CNT_W'(CLIP_LEN - 1))) state_d = StFinish;
                end else if (abort) begin
                    state_d = StFinish;
                end
            end
            StPlayRd: begin
                if (abort)     state_d = StFinish;
                else if (tick) state_d = StPlayWait;
            end
            StPlayWait: begin
                state_d = abort ? StFinish : StPlayLoad;
            end
            StPlayLoad: begin
                if (abort) begin
                    state_d = StFinish;
                end else if (ser_ready) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == cur_len) ? StFinish : StPlayRd;
                end
            end
            StFinish: begin
                if (mode_q) begin
                    if (clip_q) len1_d = cnt_q;
                    else        len0_d = cnt_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len0_q  <= '0;
            len1_q  <= '0;
            div_q   <= '0;
            mode_q  <= 1'b0;
            clip_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len0_q  <= len0_d;
            len1_q  <= len1_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            clip_q  <= clip_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr = (clip_q ? ADDR_W'(CLIP_LEN) : '0) + ADDR_W'(cnt_q);
    assign mem_we   = (state_q == StRec) && des_valid;
    assign mem_re   = (state_q == StPlayRd) && tick && !abort;
    assign ser_load = (state_q == StPlayLoad) && ser_ready && !abort;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFinish);
    assign err      = err_q;
    assign len0     = len0_q;
    assign len1     = len1_q;

endmodule

// File: tb/tb_clip_mem_sequencer.sv
// Self-checking bench for clip_mem_sequencer: directed scenarios plus randomized
// record/play sessions checked against a clip-length / address-sequence model.
module tb_clip_mem_sequencer;

    localparam int CLIP_LEN = 8;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = 4;
    localparam int RATE_DIV = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, mode = 1'b0, clip_sel = 1'b0, abort = 1'b0;
    logic des_valid = 1'b0, ser_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_we, mem_re, ser_load, busy, done, err;
    logic [CNT_W-1:0] len0, len1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int we_addr[$], we_cyc[$], re_addr[$], re_cyc[$], ld_addr[$], ld_cyc[$];
    int done_cyc[$], err_cyc[$];
    int mlen[2];

    clip_mem_sequencer #(
        .CLIP_LEN(CLIP_LEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RATE_DIV(RATE_DIV)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .clip_sel(clip_sel),
        .abort(abort), .des_valid(des_valid), .ser_ready(ser_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_re(mem_re), .ser_load(ser_load), .busy(busy), .done(done),
        .err(err), .len0(len0), .len1(len1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Event log sampled mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            if (mem_we)   begin we_addr.push_back(int'(mem_addr)); we_cyc.push_back(cyc); end
            if (mem_re)   begin re_addr.push_back(int'(mem_addr)); re_cyc.push_back(cyc); end
            if (ser_load) begin ld_addr.push_back(int'(mem_addr)); ld_cyc.push_back(cyc); end
            if (done) done_cyc.push_back(cyc);
            if (err)  err_cyc.push_back(cyc);
            if (busy) busy_cnt++;
        end
    end

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        we_addr.delete(); we_cyc.delete(); re_addr.delete(); re_cyc.delete();
        ld_addr.delete(); ld_cyc.delete(); done_cyc.delete(); err_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic pulse_start(input logic m, input logic c);
        mode = m; clip_sel = c; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic do_record(input logic c, input int n, input int gap, input bit ab_co,
                             input bit ab_after);
        pulse_start(1'b1, c);
        for (int i = 0; i < n; i++) begin
            des_valid = 1'b1;
            abort = ab_co && (i == n - 1);
            step();
            des_valid = 1'b0;
            abort = 1'b0;
            repeat (gap - 1) step();
        end
        if (ab_after) begin abort = 1'b1; step(); abort = 1'b0; end
    endtask

    // rdy: 0 = always ready, 1 = 6-cycle stall at the 2nd load, 2 = random ready
    task automatic do_play(input logic c, input int rdy, output int sc, output bit ok);
        bit stalled = 1'b0;
        ser_ready = 1'b1;
        sc = cyc;
        pulse_start(1'b0, c);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            if (rdy == 1 && !stalled && re_addr.size() == 2) begin
                stalled = 1'b1;
                ser_ready = 1'b0;
                repeat (6) step();
                ser_ready = 1'b1;
            end else if (rdy == 2) begin
                ser_ready = ($urandom_range(0, 2) != 0);
            end
            step();
        end
        ser_ready = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        repeat (2) step();
        tests++; if ({mem_addr, mem_we, mem_re, ser_load, busy, done, err} !== '0) begin
            fails++; $display("FAIL reset_outputs: got %b want 0",
                {mem_addr, mem_we, mem_re, ser_load, busy, done, err}); end
        tests++; if ({len0, len1} !== '0) begin
            fails++; $display("FAIL reset_len: got %0d/%0d want 0/0", len0, len1); end
        reset = 1'b1;
        step();
        clr();
        pulse_start(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin des_valid = 1'b1; step(); end
        #2 reset = 1'b0;
        #1;
        tests++; if (we_addr.size() !== 3) begin
            fails++; $display("FAIL pre_reset_writes: got %0d want 3", we_addr.size()); end
        tests++; if ({busy, mem_we, mem_addr, done, err, mem_re, ser_load} !== '0) begin
            fails++; $display("FAIL async_reset_outputs: got %b want 0",
                {busy, mem_we, mem_addr, done, err, mem_re, ser_load}); end
        tests++; if ({len0, len1} !== '0) begin
            fails++; $display("FAIL async_reset_len: got %0d/%0d want 0/0", len0, len1); end
        des_valid = 1'b0;
        step();
        reset = 1'b1;
        repeat (2) step();
        mlen[0] = 0; mlen[1] = 0;
        wait_idle(ok);
        tests++; if (len0 !== 0) begin
            fails++; $display("FAIL partial_clip_len: got %0d want 0", len0); end
    endtask

    task automatic test_err_empty();
        int sc;
        clr();
        sc = cyc;
        pulse_start(1'b0, 1'b1);
        repeat (4) step();
        tests++; if (err_cyc.size() !== 1 || at(err_cyc, 0) !== sc + 1) begin
            fails++; $display("FAIL err_pulse: got n=%0d cyc=%0d want n=1 cyc=%0d",
                err_cyc.size(), at(err_cyc, 0), sc + 1); end
        tests++; if (busy_cnt !== 0 || re_addr.size() !== 0 || done_cyc.size() !== 0) begin
            fails++; $display("FAIL err_no_activity: busy=%0d re=%0d done=%0d want 0/0/0",
                busy_cnt, re_addr.size(), done_cyc.size()); end
    endtask

    task automatic test_record_full();
        bit ok;
        clr();
        do_record(1'b1, 8, 3, 1'b0, 1'b0);
        wait_idle(ok);
        mlen[1] = CLIP_LEN;
        tests++; if (!ok || we_addr.size() !== CLIP_LEN) begin
            fails++; $display("FAIL full_rec_count: got %0d ok=%0d want %0d",
                we_addr.size(), ok, CLIP_LEN); end
        for (int i = 0; i < we_addr.size(); i++) begin
            tests++; if (we_addr[i] !== CLIP_LEN + i) begin
                fails++; $display("FAIL full_rec_addr[%0d]: got %0d want %0d",
                    i, we_addr[i], CLIP_LEN + i); end
        end
        tests++; if (done_cyc.size() !== 1 || at(done_cyc, 0) !== at(we_cyc, 7) + 1) begin
            fails++; $display("FAIL full_rec_done: got n=%0d cyc=%0d want cyc=%0d",
                done_cyc.size(), at(done_cyc, 0), at(we_cyc, 7) + 1); end
        tests++; if (len1 !== 8 || len0 !== 0) begin
            fails++; $display("FAIL full_rec_len: got %0d/%0d want 0/8", len0, len1); end
    endtask

    task automatic test_abort_then_play();
        bit ok;
        int sc;
        clr();
        do_record(1'b0, 5, 2, 1'b0, 1'b1);
        wait_idle(ok);
        mlen[0] = 5;
        tests++; if (!ok || we_addr.size() !== 5 || at(we_addr, 0) !== 0 || at(we_addr, 4) !== 4)
        begin fails++; $display("FAIL abort_rec_addrs: got n=%0d first=%0d last=%0d want 5/0/4",
            we_addr.size(), at(we_addr, 0), at(we_addr, 4)); end
        tests++; if (done_cyc.size() !== 1 || len0 !== 5 || len1 !== 8) begin
            fails++; $display("FAIL abort_rec_len: done=%0d len0=%0d len1=%0d want 1/5/8",
                done_cyc.size(), len0, len1); end
        clr();
        do_play(1'b0, 0, sc, ok);
        tests++; if (!ok || ld_addr.size() !== 5 || re_addr.size() !== 5) begin
            fails++; $display("FAIL play0_count: ld=%0d re=%0d ok=%0d want 5/5",
                ld_addr.size(), re_addr.size(), ok); end
        tests++; if (at(re_cyc, 0) !== sc + RATE_DIV) begin
            fails++; $display("FAIL play0_first_tick: got %0d want %0d",
                at(re_cyc, 0), sc + RATE_DIV); end
        for (int i = 0; i < ld_addr.size(); i++) begin
            tests++; if (ld_addr[i] !== i || at(re_addr, i) !== i ||
                         ld_cyc[i] !== at(re_cyc, i) + 2) begin
                fails++; $display("FAIL play0_slot[%0d]: ld=%0d re=%0d lag=%0d want %0d/%0d/2",
                    i, ld_addr[i], at(re_addr, i), ld_cyc[i] - at(re_cyc, i), i, i); end
            if (i > 0) begin
                tests++; if (at(re_cyc, i) - at(re_cyc, i - 1) !== RATE_DIV) begin
                    fails++; $display("FAIL play0_period[%0d]: got %0d want %0d", i,
                        at(re_cyc, i) - at(re_cyc, i - 1), RATE_DIV); end
            end
        end
        tests++; if (done_cyc.size() !== 1 || at(done_cyc, 0) !== at(ld_cyc, 4) + 1) begin
            fails++; $display("FAIL play0_done: got cyc=%0d want %0d",
                at(done_cyc, 0), at(ld_cyc, 4) + 1); end
    endtask

    task automatic test_play_stall();
        bit ok;
        int sc;
        clr();
        do_play(1'b1, 1, sc, ok);
        tests++; if (!ok || ld_addr.size() !== 8 || re_addr.size() !== 8) begin
            fails++; $display("FAIL stall_count: ld=%0d re=%0d ok=%0d want 8/8",
                ld_addr.size(), re_addr.size(), ok); end
        for (int i = 0; i < ld_addr.size(); i++) begin
            tests++; if (ld_addr[i] !== CLIP_LEN + i || at(re_addr, i) !== CLIP_LEN + i) begin
                fails++; $display("FAIL stall_addr[%0d]: ld=%0d re=%0d want %0d",
                    i, ld_addr[i], at(re_addr, i), CLIP_LEN + i); end
        end
        tests++; if (at(ld_cyc, 1) !== at(re_cyc, 1) + 7) begin
            fails++; $display("FAIL stall_hold: lag got %0d want 7",
                at(ld_cyc, 1) - at(re_cyc, 1)); end
        tests++; if (at(re_cyc, 2) - sc <= 0 || (at(re_cyc, 2) - sc) % RATE_DIV !== 0 ||
                     at(re_cyc, 2) <= at(ld_cyc, 1)) begin
            fails++; $display("FAIL stall_next_tick: re2=%0d ld1=%0d start=%0d",
                at(re_cyc, 2), at(ld_cyc, 1), sc); end
        tests++; if (done_cyc.size() !== 1) begin
            fails++; $display("FAIL stall_done: got %0d want 1", done_cyc.size()); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clr();
        pulse_start(1'b1, 1'b0);
        des_valid = 1'b1; step(); des_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; mode = 1'b0; clip_sel = 1'b1; step(); start = 1'b0;
            des_valid = 1'b1; step(); des_valid = 1'b0;
        end
        des_valid = 1'b1; abort = 1'b1; start = 1'b1; step();
        des_valid = 1'b0; abort = 1'b0; start = 1'b0;
        wait_idle(ok);
        repeat (6) step();
        mlen[0] = 5;
        tests++; if (!ok || we_addr.size() !== 5 || at(we_addr, 4) !== 4) begin
            fails++; $display("FAIL ign_writes: got n=%0d last=%0d want 5/4",
                we_addr.size(), at(we_addr, 4)); end
        tests++; if (len0 !== 5 || len1 !== 8) begin
            fails++; $display("FAIL ign_len: got %0d/%0d want 5/8", len0, len1); end
        tests++; if (re_addr.size() !== 0 || done_cyc.size() !== 1 || busy !== 1'b0) begin
            fails++; $display("FAIL ign_no_play: re=%0d done=%0d busy=%0d want 0/1/0",
                re_addr.size(), done_cyc.size(), busy); end
    endtask

    task automatic test_random();
        bit ok;
        int sc, n, gap, exp_n, base, other;
        logic c;
        for (int it = 0; it < 14; it++) begin
            c = 1'($urandom_range(0, 1));
            base = c ? CLIP_LEN : 0;
            other = mlen[c ? 0 : 1];
            clr();
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, CLIP_LEN + 2);
                gap = $urandom_range(1, 3);
                exp_n = (n < CLIP_LEN) ? n : CLIP_LEN;
                if (n < CLIP_LEN) begin
                    if ($urandom_range(0, 1) == 1) do_record(c, n, gap, 1'b1, 1'b0);
                    else                           do_record(c, n, gap, 1'b0, 1'b1);
                end else begin
                    do_record(c, n, gap, 1'b0, 1'b0);
                end
                wait_idle(ok);
                mlen[c] = exp_n;
                tests++; if (!ok || we_addr.size() !== exp_n) begin
                    fails++; $display("FAIL rnd%0d_rec_n: got %0d want %0d",
                        it, we_addr.size(), exp_n); end
                for (int i = 0; i < we_addr.size(); i++) begin
                    tests++; if (we_addr[i] !== base + i) begin
                        fails++; $display("FAIL rnd%0d_rec_addr[%0d]: got %0d want %0d",
                            it, i, we_addr[i], base + i); end
                end
                tests++; if (int'(len0) !== mlen[0] || int'(len1) !== mlen[1] ||
                             done_cyc.size() !== 1) begin
                    fails++; $display("FAIL rnd%0d_rec_len: got %0d/%0d done=%0d want %0d/%0d/1",
                        it, len0, len1, done_cyc.size(), mlen[0], mlen[1]); end
            end else if (mlen[c] == 0) begin
                pulse_start(1'b0, c);
                repeat (3) step();
                tests++; if (err_cyc.size() !== 1 || busy_cnt !== 0) begin
                    fails++; $display("FAIL rnd%0d_err: got err=%0d busy=%0d want 1/0",
                        it, err_cyc.size(), busy_cnt); end
            end else begin
                do_play(c, 2, sc, ok);
                tests++; if (!ok || ld_addr.size() !== mlen[c] || re_addr.size() !== mlen[c])
                begin fails++; $display("FAIL rnd%0d_play_n: ld=%0d re=%0d want %0d",
                    it, ld_addr.size(), re_addr.size(), mlen[c]); end
                for (int i = 0; i < ld_addr.size(); i++) begin
                    tests++; if (ld_addr[i] !== base + i || at(re_addr, i) !== base + i ||
                                 ld_cyc[i] < at(re_cyc, i) + 2 ||
                                 (at(re_cyc, i) - sc) % RATE_DIV !== 0 ||
                                 (i + 1 < re_cyc.size() && at(re_cyc, i + 1) <= ld_cyc[i])) begin
                        fails++; $display("FAIL rnd%0d_play[%0d]: ld=%0d re=%0d want %0d",
                            it, i, ld_addr[i], at(re_addr, i), base + i); end
                end
                tests++; if (done_cyc.size() !== 1 || int'(len0) !== mlen[0] ||
                             int'(len1) !== mlen[1] || mlen[c ? 0 : 1] !== other) begin
                    fails++; $display("FAIL rnd%0d_play_end: done=%0d len=%0d/%0d want 1/%0d/%0d",
                        it, done_cyc.size(), len0, len1, mlen[0], mlen[1]); end
            end
            repeat ($urandom_range(1, 4)) step();
        end
    endtask

    initial begin
        mlen[0] = 0;
        mlen[1] = 0;
        test_reset();
        test_err_empty();
        test_record_full();
        test_abort_then_play();
        test_play_stall();
        test_start_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
